// File: rtl/pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pass_scheduler
// Brief    : Sequences filter load, per-output MAC and psum write-back for a
//            1-D convolution pass; optional result viewer via RESULT_VIEW_EN.
// Revision : 1.0
// ============================================================================
module pass_scheduler #(
    parameter int FILT_LEN = 3,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_ifmap_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              filt_rd_en,
    output logic [ADDR_W-1:0] filt_rd_addr,
    output logic              ifmap_rd_en,
    output logic [ADDR_W-1:0] ifmap_rd_addr,
    output logic              pe_filt_we,
    output logic [ADDR_W-1:0] pe_filt_idx,
    output logic              pe_acc_clr,
    output logic              pe_mac_en,
    output logic [ADDR_W-1:0] pe_tap_idx,
    input  logic              pe_psum_valid,
    output logic              psum_wr_en,
    output logic [ADDR_W-1:0] psum_wr_addr
`ifdef RESULT_VIEW_EN
    ,
    input  logic              btn_edge,
    output logic [ADDR_W-1:0] view_addr
`endif
);

    localparam logic [ADDR_W-1:0] c_FILT_LEN = ADDR_W'(FILT_LEN);
    localparam logic [ADDR_W-1:0] c_LAST_TAP = ADDR_W'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_FILT = 3'd1,
        S_CLEAR     = 3'd2,
        S_MAC       = 3'd3,
        S_WAIT_PSUM = 3'd4,
        S_WRITE     = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_tap;
    logic [ADDR_W-1:0] r_out_idx;
    logic [ADDR_W-1:0] r_n_out;
    logic [ADDR_W-1:0] w_next_out;
    logic              w_last_out;

    assign w_next_out = r_out_idx + 1'b1;
    assign w_last_out = !(w_next_out < r_n_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tap         <= '0;
            r_out_idx     <= '0;
            r_n_out       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            filt_rd_en    <= 1'b0;
            filt_rd_addr  <= '0;
            ifmap_rd_en   <= 1'b0;
            ifmap_rd_addr <= '0;
            pe_filt_we    <= 1'b0;
            pe_filt_idx   <= '0;
            pe_acc_clr    <= 1'b0;
            pe_mac_en     <= 1'b0;
            pe_tap_idx    <= '0;
            psum_wr_en    <= 1'b0;
            psum_wr_addr  <= '0;
        end else begin
            // Every strobe is a single-cycle pulse unless re-asserted below.
            done        <= 1'b0;
            filt_rd_en  <= 1'b0;
            ifmap_rd_en <= 1'b0;
            pe_filt_we  <= 1'b0;
            pe_acc_clr  <= 1'b0;
            pe_mac_en   <= 1'b0;
            psum_wr_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ifmap_len < c_FILT_LEN) begin
                            r_state <= S_FINISH;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_n_out      <= cfg_ifmap_len - c_FILT_LEN + 1'b1;
                            err          <= 1'b0;
                            busy         <= 1'b1;
                            r_state      <= S_LOAD_FILT;
                            r_tap        <= '0;
                            filt_rd_en   <= 1'b1;
                            filt_rd_addr <= '0;
                        end
                    end
                end
                S_LOAD_FILT: begin
                    // r_tap == FILT_LEN is the drain cycle carrying the last tap write.
                    if (r_tap < c_FILT_LEN) begin
                        pe_filt_we  <= 1'b1;
                        pe_filt_idx <= r_tap;
                        r_tap       <= r_tap + 1'b1;
                        if (r_tap != c_LAST_TAP) begin
                            filt_rd_en   <= 1'b1;
                            filt_rd_addr <= r_tap + 1'b1;
                        end
                    end else begin
                        r_state    <= S_CLEAR;
                        pe_acc_clr <= 1'b1;
                        r_out_idx  <= '0;
                    end
                end
                S_CLEAR: begin
                    r_state       <= S_MAC;
                    r_tap         <= '0;
                    ifmap_rd_en   <= 1'b1;
                    ifmap_rd_addr <= r_out_idx;
                end
                S_MAC: begin
                    if (r_tap < c_FILT_LEN) begin
                        pe_mac_en  <= 1'b1;
                        pe_tap_idx <= r_tap;
                        r_tap      <= r_tap + 1'b1;
                        if (r_tap != c_LAST_TAP) begin
                            ifmap_rd_en   <= 1'b1;
                            ifmap_rd_addr <= r_out_idx + r_tap + 1'b1;
                        end
                    end else begin
                        r_state <= S_WAIT_PSUM;
                    end
                end
                S_WAIT_PSUM: begin
                    if (pe_psum_valid) begin
                        r_state      <= S_WRITE;
                        psum_wr_en   <= 1'b1;
                        psum_wr_addr <= r_out_idx;
                    end
                end
                S_WRITE: begin
                    if (!w_last_out) begin
                        r_out_idx  <= w_next_out;
                        r_state    <= S_CLEAR;
                        pe_acc_clr <= 1'b1;
                    end else begin
                        r_state <= S_FINISH;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_VIEW_EN
    logic r_view_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            view_addr <= '0;
            r_view_ok <= 1'b0;
        end else if (r_state == S_WRITE && w_last_out) begin
            view_addr <= '0;
            r_view_ok <= 1'b1;
        end else if (r_state == S_IDLE && start) begin
            r_view_ok <= 1'b0;
        end else if (r_state == S_IDLE && btn_edge && r_view_ok) begin
            view_addr <= (view_addr == r_n_out - 1'b1) ? '0 : view_addr + 1'b1;
        end
    end
`else
    // Result viewer not built: no extra state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pass_scheduler.sv
`default_nettype none
// Testbench for pass_scheduler: randomized passes, expected strobe events are
// queued per pass and matched by an independent monitor.
module tb_pass_scheduler;
    localparam int F  = 3;
    localparam int AW = 8;
    localparam int K_RF = 0, K_WF = 1, K_CLR = 2, K_RI = 3, K_MAC = 4, K_WR = 5, K_DONE = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_ifmap_len = '0;
    logic          pe_psum_valid = 1'b0;
    logic          busy, done, err;
    logic          filt_rd_en, ifmap_rd_en, pe_filt_we, pe_acc_clr, pe_mac_en, psum_wr_en;
    logic [AW-1:0] filt_rd_addr, ifmap_rd_addr, pe_filt_idx, pe_tap_idx, psum_wr_addr;
`ifdef RESULT_VIEW_EN
    logic          btn_edge = 1'b0;
    logic [AW-1:0] view_addr;
`endif

    pass_scheduler #(.FILT_LEN(F), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_ifmap_len(cfg_ifmap_len),
        .busy(busy), .done(done), .err(err),
        .filt_rd_en(filt_rd_en), .filt_rd_addr(filt_rd_addr),
        .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr),
        .pe_filt_we(pe_filt_we), .pe_filt_idx(pe_filt_idx),
        .pe_acc_clr(pe_acc_clr), .pe_mac_en(pe_mac_en), .pe_tap_idx(pe_tap_idx),
        .pe_psum_valid(pe_psum_valid),
        .psum_wr_en(psum_wr_en), .psum_wr_addr(psum_wr_addr)
`ifdef RESULT_VIEW_EN
        , .btn_edge(btn_edge), .view_addr(view_addr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { int kind; int val; int gap; } ev_t;
    ev_t exp_q[$];
    int  dly_q[$];
    int  n_vec = 0, n_err = 0, cyc = 0, last_mac_cyc = 0, resp_gen = 0;
    logic          prev_frd = 1'b0, prev_ird = 1'b0;
    logic [AW-1:0] prev_faddr = '0, prev_iaddr = '0;

    function automatic string kname(int k);
        case (k)
            K_RF:    return "filt_rd";
            K_WF:    return "filt_we";
            K_CLR:   return "acc_clr";
            K_RI:    return "ifmap_rd";
            K_MAC:   return "mac";
            K_WR:    return "psum_wr";
            default: return "done";
        endcase
    endfunction

    function automatic void push_ev(int kind, int val, int gap);
        ev_t e;
        e.kind = kind; e.val = val; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    function automatic void check_ev(int kind, int val);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got %s %0d, expected no event", kname(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_err++;
                $display("FAIL event: got %s %0d, expected %s %0d", kname(kind), val, kname(e.kind), e.val);
            end else if (kind == K_WR) begin
                n_vec++;
                if (cyc - last_mac_cyc != e.gap) begin
                    n_err++;
                    $display("FAIL psum_wait: write %0d cycles after last mac, expected %0d", cyc - last_mac_cyc, e.gap);
                end
            end
        end
    endfunction

    // Monitor: every strobe the DUT presents consumes one expected event.
    always @(negedge clk) begin
        int nstb;
        cyc = cyc + 1;
        if (rst) begin
            if (pe_filt_we) begin
                n_vec++;
                if (!(prev_frd && prev_faddr == pe_filt_idx)) begin
                    n_err++;
                    $display("FAIL filt_we_lag: idx %0d, previous read en=%0d addr=%0d", pe_filt_idx, prev_frd, prev_faddr);
                end
                check_ev(K_WF, int'(pe_filt_idx));
            end
            if (filt_rd_en) check_ev(K_RF, int'(filt_rd_addr));
            if (pe_mac_en) begin
                n_vec++;
                if (!prev_ird) begin
                    n_err++;
                    $display("FAIL mac_lag: mac tap %0d without ifmap read in previous cycle", pe_tap_idx);
                end
                check_ev(K_MAC, int'(pe_tap_idx));
                if (pe_tap_idx == AW'(F - 1)) last_mac_cyc = cyc;
            end
            if (ifmap_rd_en) check_ev(K_RI, int'(ifmap_rd_addr));
            if (pe_acc_clr)  check_ev(K_CLR, 0);
            if (psum_wr_en)  check_ev(K_WR, int'(psum_wr_addr));
            if (done) begin
                check_ev(K_DONE, int'(err));
                n_vec++;
                if (busy) begin
                    n_err++;
                    $display("FAIL busy_at_done: busy=%0d, expected 0", busy);
                end
            end
            nstb = int'(filt_rd_en) + int'(ifmap_rd_en) + int'(psum_wr_en);
            if (nstb > 0) begin
                n_vec++;
                if (nstb > 1) begin
                    n_err++;
                    $display("FAIL exclusive: %0d buffer strobes together, expected at most 1", nstb);
                end
            end
        end
        prev_frd   = filt_rd_en;
        prev_faddr = filt_rd_addr;
        prev_ird   = ifmap_rd_en;
        prev_iaddr = ifmap_rd_addr;
    end

    // PE model: result becomes valid a per-output number of cycles after the last MAC.
    initial begin
        int d, g;
        forever begin
            @(negedge clk);
            if (rst && pe_mac_en && pe_tap_idx == AW'(F - 1)) begin
                d = 0;
                if (dly_q.size() > 0) d = dly_q.pop_front();
                g = resp_gen;
                for (int i = 0; i <= d; i++) begin
                    @(negedge clk);
                    if (g != resp_gen) break;
                end
                if (g == resp_gen) begin
                    pe_psum_valid = 1'b1;
                    @(negedge clk);
                    pe_psum_valid = 1'b0;
                end
            end
        end
    end

    // Reference: the ordered list of strobe events one pass must produce.
    function automatic void model_pass(int len, int slow_o, int slow_d, bit rnd);
        int n, d;
        if (len < F) begin
            push_ev(K_DONE, 1, 0);
            return;
        end
        n = len - F + 1;
        for (int k = 0; k < F; k++) begin
            push_ev(K_RF, k, 0);
            push_ev(K_WF, k, 0);
        end
        for (int o = 0; o < n; o++) begin
            d = (o == slow_o) ? slow_d : (rnd ? int'($urandom_range(0, 3)) : 0);
            dly_q.push_back(d);
            push_ev(K_CLR, 0, 0);
            for (int k = 0; k < F; k++) begin
                push_ev(K_RI, o + k, 0);
                push_ev(K_MAC, k, 0);
            end
            push_ev(K_WR, o, d + 2);
        end
        push_ev(K_DONE, 0, 0);
    endfunction

    task automatic run_pass(input int len, input int slow_o, input int slow_d, input bit restart, input bit rnd);
        bit bad, got, wr_seen, fired;
        bad = (len < F);
        model_pass(len, slow_o, slow_d, rnd);
        cfg_ifmap_len = AW'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_ifmap_len = AW'($urandom);
        n_vec++;
        if (busy !== !bad) begin
            n_err++;
            $display("FAIL busy_after_start: busy=%0d, expected %0d", busy, !bad);
        end
        got = 0; wr_seen = 0; fired = 0;
        for (int c = 0; c < 6000 && !got; c++) begin
            if (done) got = 1;
            else begin
                if (psum_wr_en) wr_seen = 1;
                if (restart && wr_seen && !fired && ifmap_rd_en) begin
                    start = 1'b1;
                    cfg_ifmap_len = AW'(1);
                    fired = 1;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout: len %0d, done=%0d, expected 1", len, done);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (err !== bad) begin
            n_err++;
            $display("FAIL err_hold: err=%0d, expected %0d", err, bad);
        end
    endtask

    function automatic logic [6*AW+9:0] all_outs();
        return {busy, done, err, filt_rd_en, ifmap_rd_en, pe_filt_we, pe_acc_clr, pe_mac_en, psum_wr_en,
                1'b0, filt_rd_addr, ifmap_rd_addr, pe_filt_idx, pe_tap_idx, psum_wr_addr, 8'h00};
    endfunction

`ifdef RESULT_VIEW_EN
    task automatic press_btn(input int exp_v);
        btn_edge = 1'b1;
        @(negedge clk);
        btn_edge = 1'b0;
        @(negedge clk);
        n_vec++;
        if (view_addr !== AW'(exp_v)) begin
            n_err++;
            $display("FAIL view_addr: got %0d, expected %0d", view_addr, exp_v);
        end
    endtask
`endif

    initial begin
        bit got;
        #1 rst = 1'b0;
        #2;
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 0", all_outs());
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_pass(5, -1, 0, 1'b0, 1'b0);
`ifdef RESULT_VIEW_EN
        n_vec++;
        if (view_addr !== '0) begin
            n_err++;
            $display("FAIL view_after_pass: got %0d, expected 0", view_addr);
        end
        press_btn(1); press_btn(2); press_btn(0); press_btn(1);
`endif
        run_pass(2, -1, 0, 1'b0, 1'b1);
`ifdef RESULT_VIEW_EN
        press_btn(1);
`endif
        run_pass(5, -1, 0, 1'b1, 1'b1);
        run_pass(5, 1, 20, 1'b0, 1'b0);

        // Reset cut into WAIT_PSUM of output 0.
        model_pass(5, 0, 30, 1'b0);
        cfg_ifmap_len = AW'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (pe_mac_en && pe_tap_idx == AW'(F - 1)) got = 1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL reach_wait: last mac not seen, mac_en=%0d", pe_mac_en);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h, expected 0", all_outs());
        end
        resp_gen++;
        exp_q.delete();
        dly_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_pass(3, -1, 0, 1'b0, 1'b1);

        run_pass(0, -1, 0, 1'b0, 1'b1);
        run_pass(255, -1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) run_pass(int'($urandom_range(0, 12)), -1, 0, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_events: %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
